// File: rtl/morse_pkg.sv
// Shared definitions for the Morse element sequencer: symbol codes,
// per-symbol mark/space unit counts and the FSM state encoding.
package morse_pkg;

    // Unit counter width; the longest phase is the 6-unit word-gap space.
    localparam int UNIT_W = 3;

    typedef enum logic [1:0] {
        SYM_DOT  = 2'd0,
        SYM_DASH = 2'd1,
        SYM_LGAP = 2'd2,
        SYM_WGAP = 2'd3
    } sym_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2
    } state_e;

    // Mark (key down) and space (key up) lengths in Morse units.
    localparam logic [UNIT_W-1:0] DOT_MARK   = 3'd1;
    localparam logic [UNIT_W-1:0] DOT_SPACE  = 3'd1;
    localparam logic [UNIT_W-1:0] DASH_MARK  = 3'd3;
    localparam logic [UNIT_W-1:0] DASH_SPACE = 3'd1;
    localparam logic [UNIT_W-1:0] LGAP_MARK  = 3'd0;
    localparam logic [UNIT_W-1:0] LGAP_SPACE = 3'd2;
    localparam logic [UNIT_W-1:0] WGAP_MARK  = 3'd0;
    localparam logic [UNIT_W-1:0] WGAP_SPACE = 3'd6;

    typedef struct packed {
        logic [UNIT_W-1:0] mark;
        logic [UNIT_W-1:0] space;
    } units_t;

    // Look up the mark/space unit pair for a symbol code.
    function automatic units_t sym_units(input logic [1:0] code);
        units_t u;
        case (code)
            SYM_DOT:  u = '{mark: DOT_MARK,  space: DOT_SPACE};
            SYM_DASH: u = '{mark: DASH_MARK, space: DASH_SPACE};
            SYM_LGAP: u = '{mark: LGAP_MARK, space: LGAP_SPACE};
            default:  u = '{mark: WGAP_MARK, space: WGAP_SPACE};
        endcase
        return u;
    endfunction

endpackage

// File: rtl/unit_tick_gen.sv
// Programmable unit-length divider. After a restart the first tick comes
// exactly div cycles later, then every div cycles until the next restart.
// div must be non-zero; the counter never exceeds div, so it cannot wrap.
module unit_tick_gen #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = (cnt == div);

    // Divider counter: reload to 1 on restart or tick, otherwise count up.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= DIV_W'(1);
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/morse_element_sequencer.sv
// Turns one Morse symbol (dot, dash, letter gap, word gap) into a timed
// key_out waveform: a mark phase of mark*D cycles followed by a space phase
// of space*D cycles, with done flagging the final cycle of the symbol.
module morse_element_sequencer
    import morse_pkg::*;
#(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] unit_div,
    input  logic             sym_valid,
    input  logic [1:0]       sym_code,
    output logic             sym_ready,
    output logic             key_out,
    output logic             busy,
    output logic             done
);

    state_e            state;
    state_e            next_state;
    units_t            units_q;
    logic [DIV_W-1:0]  d_q;
    logic [UNIT_W-1:0] unit_cnt;
    logic              tick;
    logic              restart;
    logic              mark_last;
    logic              space_last;

    // The final tick of each phase ends that phase.
    assign mark_last  = tick && (unit_cnt == units_q.mark  - UNIT_W'(1));
    assign space_last = tick && (unit_cnt == units_q.space - UNIT_W'(1));

    // Hold the divider at its start point while idle and realign it on every
    // phase change, so each phase starts with a full unit.
    assign restart = (state == ST_IDLE) || (next_state != state);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: acceptance only in IDLE, phases end on their last tick.
    always_comb begin
        // NOTE: default first so every path assigns next_state (no latch).
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (sym_valid) begin
                    next_state = (sym_units(sym_code).mark != '0) ? ST_MARK : ST_SPACE;
                end
            end
            ST_MARK: begin
                if (mark_last) next_state = ST_SPACE;
            end
            ST_SPACE: begin
                if (space_last) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        sym_ready = (state == ST_IDLE);
        busy      = (state == ST_MARK) || (state == ST_SPACE);
        done      = (state == ST_SPACE) && space_last;
    end

    // Symbol parameters are captured only on acceptance and held while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            units_q <= '0;
            d_q     <= DIV_W'(1);
        end else if ((state == ST_IDLE) && sym_valid) begin
            units_q <= sym_units(sym_code);
            d_q     <= (unit_div == '0) ? DIV_W'(1) : unit_div;
        end
    end

    // Unit counter: counts completed units within the current phase.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            unit_cnt <= '0;
        end else if (tick) begin
            unit_cnt <= unit_cnt + UNIT_W'(1);
        end
    end

    // Registered key output, high for every cycle spent in MARK.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_out <= 1'b0;
        end else begin
            key_out <= (next_state == ST_MARK);
        end
    end

    unit_tick_gen #(
        .DIV_W (DIV_W)
    ) u_unit_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .div     (d_q),
        .tick    (tick)
    );

endmodule

// File: tb/tb_morse_element_sequencer.sv
// Directed bench for morse_element_sequencer. Each accepted symbol pushes its
// expected key-high and busy cycle counts; a monitor pops and compares them
// when done pulses. Cycle-exact checks cover the traced dot and reset abort.
module tb_morse_element_sequencer;
    import morse_pkg::*;

    localparam int DIV_W = 24;

    logic             clk = 1'b0;
    logic             rst;
    logic [DIV_W-1:0] unit_div;
    logic             sym_valid;
    logic [1:0]       sym_code;
    logic             sym_ready;
    logic             key_out;
    logic             busy;
    logic             done;

    typedef struct {
        int key_cycles;
        int busy_cycles;
    } exp_t;

    exp_t sb[$];
    int   n_cmp     = 0;
    int   n_bad     = 0;
    int   key_acc   = 0;
    int   busy_acc  = 0;
    int   done_seen = 0;

    morse_element_sequencer #(
        .DIV_W (DIV_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .unit_div  (unit_div),
        .sym_valid (sym_valid),
        .sym_code  (sym_code),
        .sym_ready (sym_ready),
        .key_out   (key_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one symbol from IDLE, wait (bounded) for the return to IDLE.
    task automatic run_symbol(input logic [1:0] code, input int div,
                              input int key, input int bsy);
        exp_t e;
        int   waited;
        e.key_cycles  = key;
        e.busy_cycles = bsy;
        sym_valid = 1'b1;
        sym_code  = code;
        unit_div  = DIV_W'(div);
        sb.push_back(e);
        @(negedge clk);
        sym_valid = 1'b0;
        waited = 0;
        while (!sym_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("idle_return_code%0d_div%0d", code, div), int'(sym_ready), 1);
        check("sb_drained", sb.size(), 0);
    endtask

    // Monitor: accumulate key-high and busy cycles, compare on done.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            key_acc  = 0;
            busy_acc = 0;
        end else begin
            if (key_out) key_acc++;
            if (busy)    busy_acc++;
            if (done) begin
                done_seen++;
                check("sb_nonempty_at_done", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("mark_cycles", key_acc, e.key_cycles);
                    check("busy_cycles", busy_acc, e.busy_cycles);
                end
                key_acc  = 0;
                busy_acc = 0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        exp_t e;
        int   done_before;
        int   waited;

        rst       = 1'b1;
        sym_valid = 1'b0;
        sym_code  = 2'd0;
        unit_div  = '0;
        repeat (3) @(negedge clk);
        check("rst_sym_ready", int'(sym_ready), 1);
        check("rst_busy",      int'(busy),      0);
        check("rst_key_out",   int'(key_out),   0);
        check("rst_done",      int'(done),      0);
        rst = 1'b0;
        @(negedge clk);

        // Dot, D=4, accepted in cycle 0: traced cycle by cycle.
        e.key_cycles = 4; e.busy_cycles = 8;
        sb.push_back(e);
        sym_valid = 1'b1; sym_code = SYM_DOT; unit_div = DIV_W'(4);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) sym_valid = 1'b0;
            check($sformatf("dot_key_c%0d", c),   int'(key_out),   int'(c <= 4));
            check($sformatf("dot_done_c%0d", c),  int'(done),      int'(c == 8));
            check($sformatf("dot_ready_c%0d", c), int'(sym_ready), int'(c == 9));
        end

        // Assorted symbols and divisors, including D=0 treated as D=1.
        run_symbol(SYM_DASH, 4, 12, 16);
        run_symbol(SYM_WGAP, 2, 0, 12);
        run_symbol(SYM_DOT,  0, 1, 2);
        run_symbol(SYM_LGAP, 3, 0, 6);
        run_symbol(SYM_DASH, 1, 3, 4);

        // Reset in cycle 5 of a D=4 dash aborts it without done.
        done_before = done_seen;
        sym_valid = 1'b1; sym_code = SYM_DASH; unit_div = DIV_W'(4);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) sym_valid = 1'b0;
        end
        check("abort_key_c5", int'(key_out), 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_key_c6",   int'(key_out),   0);
        check("abort_ready_c6", int'(sym_ready), 1);
        check("abort_busy_c6",  int'(busy),      0);
        check("abort_done_c6",  int'(done),      0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_done", done_seen, done_before);

        // Reset wins over acceptance in the same cycle.
        rst = 1'b1; sym_valid = 1'b1; sym_code = SYM_DOT; unit_div = DIV_W'(4);
        @(negedge clk);
        check("rst_prio_busy",  int'(busy),      0);
        check("rst_prio_ready", int'(sym_ready), 1);
        rst = 1'b0; sym_valid = 1'b0;
        @(negedge clk);
        check("rst_prio_idle", int'(busy), 0);

        // sym_valid held with changing code/divisor during a dot.
        e.key_cycles = 4; e.busy_cycles = 8;
        sb.push_back(e);
        sym_valid = 1'b1; sym_code = SYM_DOT; unit_div = DIV_W'(4);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("hold_busy_c%0d", c), int'(busy), 1);
            sym_code = 2'(c);
            unit_div = DIV_W'((c * 3) % 7);
        end
        @(negedge clk);
        check("hold_ready_c9", int'(sym_ready), 1);
        e.key_cycles = 6; e.busy_cycles = 8;
        sb.push_back(e);
        sym_code = SYM_DASH; unit_div = DIV_W'(2);
        @(negedge clk);
        sym_valid = 1'b0;
        waited = 0;
        while (!sym_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("hold_second_idle", int'(sym_ready), 1);
        check("hold_sb_drained",  sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/morse_element_sequencer.md
MORSE_ELEMENT_SEQUENCER -- requirements
Module: morse_element_sequencer

Interface
REQ-001 SHALL have parameter DIV_W, default 24, meaning the width of the unit-length divisor in clock cycles.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port unit_div  input  DIV_W  clock cycles per Morse unit, sampled only on symbol acceptance.
REQ-005 SHALL have port sym_valid  input  1  requester presents a symbol.
REQ-006 SHALL have port sym_code  input  2  symbol: 0 dot, 1 dash, 2 letter gap, 3 word gap.
REQ-007 SHALL have port sym_ready  output  1  sequencer can accept a symbol.
REQ-008 SHALL have port key_out  output  1  keyed carrier (1 = tone/LED on).
REQ-009 SHALL have port busy  output  1  symbol in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse on the final cycle of a symbol.

Function
REQ-011 SHALL implement FSM states IDLE, MARK, SPACE; sym_ready = 1 only in IDLE; busy = 1 in MARK or SPACE.
REQ-012 SHALL accept a symbol on a cycle where sym_valid and sym_ready are both 1, latching sym_code and unit_div (D) on that edge.
REQ-013 SHALL treat D = 0 as D = 1.
REQ-014 SHALL use units (mark, space): dot (1,1), dash (3,1), letter gap (0,2), word gap (0,6).
REQ-015 SHALL, for mark > 0, go IDLE -> MARK at acceptance and drive key_out = 1 for exactly mark*D cycles starting the cycle after acceptance.
REQ-016 SHALL, for mark = 0, go IDLE -> SPACE directly with no key_out high cycle.
REQ-017 SHALL go MARK -> SPACE after the last mark cycle and hold key_out = 0 for exactly space*D cycles.
REQ-018 SHALL assert done in the last SPACE cycle and return to IDLE on the next edge; total symbol period = (mark+space)*D + 1 cycles including the IDLE acceptance cycle.
REQ-019 SHALL ignore sym_valid, sym_code and unit_div while busy; changes have no effect on the running symbol.
REQ-020 SHALL count units with a unit-tick sub-module restarted at every acceptance and state change, so the first tick occurs exactly D cycles after the restart; no phase is carried over from earlier symbols.
REQ-021 SHALL use a unit counter wide enough for 6 and a divider counter DIV_W wide; neither may wrap within a symbol.
REQ-022 SHALL keep key_out registered (glitch-free), changing only on clk edges.

Reset
REQ-023 SHALL, when rst = 1 at a clk edge, force state IDLE, key_out 0, busy 0, done 0, sym_ready 1 on the following cycle, and clear all counters.
REQ-024 SHALL abort any symbol in progress on reset, without emitting done; rst takes priority over acceptance in the same cycle.

Structure
REQ-025 SHALL place sym_code constants, mark/space unit counts and the FSM state encoding in shared package morse_pkg.
REQ-026 SHALL instantiate one sub-module unit_tick_gen: a programmable divider with restart input, emitting a one-cycle tick every D cycles.

Verification
REQ-027 SHALL cover a dot with D=4 accepted at cycle 0 -> key_out 1 on cycles 1-4, 0 on cycles 5-8, done on cycle 8, sym_ready 1 on cycle 9.
REQ-028 SHALL cover a dash with D=4 -> key_out high exactly 12 cycles, then low 4 cycles, then done.
REQ-029 SHALL cover a word gap with D=2 -> key_out never high, busy for 12 cycles, done on the 12th cycle.
REQ-030 SHALL cover a dot with unit_div=0 -> behaves as D=1: key_out high 1 cycle, low 1 cycle, done on cycle 2.
REQ-031 SHALL cover rst asserted on cycle 5 of a D=4 dash -> key_out 0 and sym_ready 1 from cycle 6, and no done pulse.
REQ-032 SHALL cover sym_valid held high with changing sym_code/unit_div during a dot -> only the first symbol runs with its original D, and the next one is accepted in IDLE.
